// File: rtl/mcu_arb_pkg.sv
// Shared types and default parameters for the single-port RAM arbiter.
// Optional feature macro: SP_RAM_ARB_RR_EN (round-robin conflict resolution).
package mcu_arb_pkg;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefCntWidth  = 16;

  // Which requester owns the access whose response is due this cycle.
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  // Bit position of each requester in the req/gnt vectors.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter: one-hot grant plus winner index.
// SP_RAM_ARB_RR_EN defined: round-robin on conflict (last-grant register).
// SP_RAM_ARB_RR_EN undefined: fixed priority, DATA over INSTR.
module rr_arb2
  import mcu_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output port_idx_e  idx_o
);

`ifdef SP_RAM_ARB_RR_EN
  port_idx_e last_q, last_d;

  // Winner select: a lone request wins, a conflict goes to the port not granted last.
  always_comb begin
    idx_o = PORT_INSTR;
    case (req_i)
      2'b01:   idx_o = PORT_INSTR;
      2'b10:   idx_o = PORT_DATA;
      2'b11:   idx_o = (last_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
      default: idx_o = PORT_INSTR;
    endcase
  end

  // Last-grant only moves on cycles that actually grant something.
  assign last_d = (|req_i) ? idx_o : last_q;

  // Last-grant register; reset to DATA so the first conflict goes to INSTR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // No state in fixed-priority mode; clock and reset are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;

  // Winner select: DATA beats INSTR on conflict.
  always_comb begin
    idx_o = PORT_INSTR;
    case (req_i)
      2'b01:   idx_o = PORT_INSTR;
      2'b10:   idx_o = PORT_DATA;
      2'b11:   idx_o = PORT_DATA;
      default: idx_o = PORT_INSTR;
    endcase
  end
`endif

  assign gnt_o = (|req_i) ? (2'b01 << idx_o) : 2'b00;

endmodule

// File: rtl/sp_ram_port_arbiter.sv
// Shares one single-port RAM (one-cycle registered read) between the core's
// instruction-fetch and data ports, with saturating wait-cycle counters.
// SP_RAM_ARB_RR_EN selects round-robin arbitration; default is DATA-first.
module sp_ram_port_arbiter
  import mcu_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Instruction port
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  // Data port
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  // RAM side
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  // Performance debug
  input  logic                    clr_cnt_i,
  output logic [CNT_WIDTH-1:0]    instr_wait_cnt_o,
  output logic [CNT_WIDTH-1:0]    data_wait_cnt_o
);

  logic [1:0] req, gnt;
  port_idx_e  win_idx;
  owner_e     owner_q, owner_d;

  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;

  // Requests are masked while in reset so no grant or RAM enable leaks out.
  assign req = {data_req_i & rst_ni, instr_req_i & rst_ni};

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];

  // RAM request mux: winner drives the RAM; idle fields are held at zero.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (|gnt) begin
      mem_en_o = 1'b1;
      if (win_idx == PORT_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        // Instruction fetches are always full-word reads.
        mem_be_o   = '1;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  // Owner next-state: tag this cycle's winner so its response is routed next cycle.
  always_comb begin
    owner_d = OWNER_NONE;
    if (|gnt) begin
      owner_d = (win_idx == PORT_DATA) ? OWNER_DATA : OWNER_INSTR;
    end
  end

  // Owner register; async reset drops any in-flight response immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Response outputs: one-cycle rvalid to the owner, rdata shared from the RAM.
  always_comb begin
    instr_rvalid_o = (owner_q == OWNER_INSTR);
    data_rvalid_o  = (owner_q == OWNER_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

  // Wait-counter next-state: count stalled cycles, saturate, clear wins over increment.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    data_cnt_d  = data_cnt_q;
    if (clr_cnt_i) begin
      instr_cnt_d = '0;
      data_cnt_d  = '0;
    end else begin
      if (req[0] && !gnt[0] && !(&instr_cnt_q)) instr_cnt_d = instr_cnt_q + 1'b1;
      if (req[1] && !gnt[1] && !(&data_cnt_q))  data_cnt_d  = data_cnt_q + 1'b1;
    end
  end

  // Wait-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_cnt_q <= '0;
      data_cnt_q  <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

  assign instr_wait_cnt_o = instr_cnt_q;
  assign data_wait_cnt_o  = data_cnt_q;

endmodule

// File: tb/tb_sp_ram_port_arbiter.sv
// Self-checking bench for sp_ram_port_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_sp_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef SP_RAM_ARB_RR_EN
  // Round-robin never starves a port, so a narrower counter keeps saturation runs short.
  localparam int CW = 12;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          ireq, dreq, dwe, clr;
  logic [AW-1:0] iaddr, daddr;
  logic [BW-1:0] dbe;
  logic [DW-1:0] dwdata;
  logic          instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [DW-1:0] instr_rdata, data_rdata;
  logic          mem_en, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] instr_wait_cnt, data_wait_cnt;

  sp_ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .instr_req_i      (ireq),
    .instr_addr_i     (iaddr),
    .instr_gnt_o      (instr_gnt),
    .instr_rvalid_o   (instr_rvalid),
    .instr_rdata_o    (instr_rdata),
    .data_req_i       (dreq),
    .data_we_i        (dwe),
    .data_be_i        (dbe),
    .data_addr_i      (daddr),
    .data_wdata_i     (dwdata),
    .data_gnt_o       (data_gnt),
    .data_rvalid_o    (data_rvalid),
    .data_rdata_o     (data_rdata),
    .mem_en_o         (mem_en),
    .mem_we_o         (mem_we),
    .mem_be_o         (mem_be),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata),
    .clr_cnt_i        (clr),
    .instr_wait_cnt_o (instr_wait_cnt),
    .data_wait_cnt_o  (data_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return (32'(i) * 32'h0101_0001) ^ 32'hA5C3_0F1E;
  endfunction

  // RAM environment: registered read, byte-enabled write, driven by the DUT's RAM port.
  logic          ram_init;
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  // Reference model: who wins, what response is due, how long each port has waited.
  logic [DW-1:0] ref_mem [256];
  int            m_last;          // 0 = instr, 1 = data
  bit            m_ivld, m_dvld, m_dread;
  logic [DW-1:0] m_rdata;
  int            m_icnt, m_dcnt;
  int            n_cmp, n_err;

  function automatic int winner(bit ir, bit dr);
    if (!ir && !dr) return -1;
    if (ir && !dr) return 0;
    if (!ir && dr) return 1;
`ifdef SP_RAM_ARB_RR_EN
    return (m_last == 1) ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_ivld = 0; m_dvld = 0; m_dread = 0;
    m_icnt = 0; m_dcnt = 0; m_last = 1;
  endtask

  // Advance one clock, updating the model from the inputs held this cycle.
  task automatic tick();
    int w;
    w = winner(ireq, dreq);
    m_ivld  = (w == 0);
    m_dvld  = (w == 1);
    m_dread = (w == 1) && !dwe;
    if (w == 0) m_rdata = ref_mem[iaddr[9:2]];
    else if (w == 1 && !dwe) m_rdata = ref_mem[daddr[9:2]];
    else if (w == 1) begin
      for (int b = 0; b < BW; b++)
        if (dbe[b]) ref_mem[daddr[9:2]][8*b +: 8] = dwdata[8*b +: 8];
    end
    if (clr) begin
      m_icnt = 0; m_dcnt = 0;
    end else begin
      if (ireq && w != 0 && m_icnt < CMAX) m_icnt++;
      if (dreq && w != 1 && m_dcnt < CMAX) m_dcnt++;
    end
    if (w >= 0) m_last = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ireq = 0; dreq = 0; dwe = 0; clr = 0;
    iaddr = '0; daddr = '0; dbe = '0; dwdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    // Requests raised during reset must not be granted.
    ireq = 1; dreq = 1; iaddr = 16'h0100; daddr = 16'h0200;
    #1;
    n_cmp++;
    if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_en, mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_be, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mem_bus: be=%h addr=%h wdata=%h want 0", mem_be, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (instr_wait_cnt !== '0 || data_wait_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", instr_wait_cnt, data_wait_cnt);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_instr_reads();
    for (int k = 0; k < 4; k++) begin
      ireq = (k < 3); iaddr = 16'(4 * k); dreq = 0;
      #1;
      if (k < 3) begin
        n_cmp++;
        if (instr_gnt !== 1'b1 || mem_addr !== iaddr || mem_be !== 4'hF || mem_we !== 1'b0) begin
          n_err++;
          $display("FAIL ifetch_req[%0d]: gnt=%b addr=%h be=%h we=%b want 1 %h f 0",
                   k, instr_gnt, mem_addr, mem_be, mem_we, iaddr);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (instr_rvalid !== 1'b1 || data_rvalid !== 1'b0 || instr_rdata !== m_rdata) begin
          n_err++;
          $display("FAIL ifetch_rsp[%0d]: rvalid=%b drvalid=%b rdata=%h want 1 0 %h",
                   k - 1, instr_rvalid, data_rvalid, instr_rdata, m_rdata);
        end
      end
      tick();
    end
    n_cmp++;
    if (instr_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ifetch_idle: rvalid=%b want 0", instr_rvalid);
    end
  endtask

  task automatic test_data_write_read();
    dreq = 1; dwe = 1; dbe = 4'b0011; daddr = 16'h0010; dwdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (data_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== dwdata) begin
      n_err++;
      $display("FAIL dwrite_req: gnt=%b we=%b be=%b wdata=%h want 1 1 0011 deadbeef",
               data_gnt, mem_we, mem_be, mem_wdata);
    end
    tick();
    dwe = 0; dbe = 4'hF; dwdata = '0;
    #1;
    n_cmp++;
    if (data_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL dwrite_rsp: rvalid=%b want 1", data_rvalid);
    end
    tick();
    dreq = 0;
    #1;
    n_cmp++;
    if (data_rvalid !== 1'b1 || data_rdata !== m_rdata || data_rdata[15:0] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL dread_rsp: rvalid=%b rdata=%h want 1 %h", data_rvalid, data_rdata, m_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bit exp_i;
    reset_dut();
    ireq = 1; iaddr = 16'h0020; dreq = 1; dwe = 0; dbe = 4'hF; daddr = 16'h0030;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef SP_RAM_ARB_RR_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = 0;
`endif
      n_cmp++;
      if (instr_gnt !== exp_i || data_gnt !== !exp_i) begin
        n_err++;
        $display("FAIL contend_gnt[%0d]: i=%b d=%b want %b %b", k, instr_gnt, data_gnt,
                 exp_i, !exp_i);
      end
      tick();
    end
    ireq = 0; dreq = 0;
    #1;
    n_cmp++;
`ifdef SP_RAM_ARB_RR_EN
    if (instr_wait_cnt !== CW'(4) || data_wait_cnt !== CW'(4)) begin
      n_err++;
      $display("FAIL contend_cnt: got %0d/%0d want 4/4", instr_wait_cnt, data_wait_cnt);
    end
`else
    if (instr_wait_cnt !== CW'(8) || data_wait_cnt !== CW'(0)) begin
      n_err++;
      $display("FAIL contend_cnt: got %0d/%0d want 8/0", instr_wait_cnt, data_wait_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_saturation();
    int n;
`ifdef SP_RAM_ARB_RR_EN
    n = 2 * CMAX + 10;
`else
    n = CMAX + 5;
`endif
    ireq = 1; iaddr = 16'h0040; dreq = 1; dwe = 0; dbe = 4'hF; daddr = 16'h0044;
    for (int k = 0; k < n; k++) tick();
    n_cmp++;
    if (instr_wait_cnt !== CW'(m_icnt) || instr_wait_cnt !== CW'(CMAX)) begin
      n_err++;
      $display("FAIL sat_instr: got %h want %h", instr_wait_cnt, CW'(CMAX));
    end
    n_cmp++;
    if (data_wait_cnt !== CW'(m_dcnt)) begin
      n_err++;
      $display("FAIL sat_data: got %h want %h", data_wait_cnt, CW'(m_dcnt));
    end
    // Line the clear up with a cycle in which instr is stalled.
    if (winner(ireq, dreq) == 0) tick();
    clr = 1;
    tick();
    clr = 0;
    #1;
    n_cmp++;
    if (instr_wait_cnt !== '0 || data_wait_cnt !== '0) begin
      n_err++;
      $display("FAIL clr_stalled: got %0d/%0d want 0/0", instr_wait_cnt, data_wait_cnt);
    end
    tick();
    n_cmp++;
    if (instr_wait_cnt !== CW'(m_icnt) || data_wait_cnt !== CW'(m_dcnt)) begin
      n_err++;
      $display("FAIL post_clr: got %0d/%0d want %0d/%0d", instr_wait_cnt, data_wait_cnt,
               m_icnt, m_dcnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_access();
    dreq = 1; dwe = 0; dbe = 4'hF; daddr = 16'h0050;
    #1;
    tick();
    dreq = 0;
    #1;
    n_cmp++;
    if (data_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: rvalid=%b want 1", data_rvalid);
    end
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_drop: d=%b i=%b want 0 0", data_rvalid, instr_rvalid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    n_cmp++;
    if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_post: d=%b i=%b en=%b want 0 0 0", data_rvalid, instr_rvalid,
               mem_en);
    end
  endtask

  task automatic test_random();
    bit ipend, dpend;
    int w;
    ipend = 0; dpend = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ipend && $urandom_range(0, 2) != 0) begin
        ipend = 1;
        iaddr = 16'($urandom_range(0, 255)) << 2;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend  = 1;
        dwe    = $urandom_range(0, 1) == 1;
        dbe    = 4'($urandom_range(1, 15));
        daddr  = 16'($urandom_range(0, 255)) << 2;
        dwdata = $urandom;
      end
      ireq = ipend; dreq = dpend;
      clr  = ($urandom_range(0, 15) == 0);
      #1;
      w = winner(ireq, dreq);
      n_cmp++;
      if (instr_gnt !== (w == 0) || data_gnt !== (w == 1) || mem_en !== (w >= 0)) begin
        n_err++;
        $display("FAIL rnd_gnt[%0d]: i=%b d=%b en=%b want winner %0d", k, instr_gnt, data_gnt,
                 mem_en, w);
      end
      if (w == 0) begin
        n_cmp++;
        if (mem_addr !== iaddr || mem_we !== 1'b0 || mem_be !== 4'hF) begin
          n_err++;
          $display("FAIL rnd_ibus[%0d]: addr=%h we=%b be=%h want %h 0 f", k, mem_addr, mem_we,
                   mem_be, iaddr);
        end
      end else if (w == 1) begin
        n_cmp++;
        if (mem_addr !== daddr || mem_we !== dwe || mem_be !== dbe || mem_wdata !== dwdata) begin
          n_err++;
          $display("FAIL rnd_dbus[%0d]: addr=%h we=%b be=%h wd=%h want %h %b %h %h", k,
                   mem_addr, mem_we, mem_be, mem_wdata, daddr, dwe, dbe, dwdata);
        end
      end
      n_cmp++;
      if (instr_rvalid !== m_ivld || data_rvalid !== m_dvld) begin
        n_err++;
        $display("FAIL rnd_rvalid[%0d]: i=%b d=%b want %b %b", k, instr_rvalid, data_rvalid,
                 m_ivld, m_dvld);
      end
      if (m_ivld || m_dread) begin
        n_cmp++;
        if ((m_ivld ? instr_rdata : data_rdata) !== m_rdata) begin
          n_err++;
          $display("FAIL rnd_rdata[%0d]: got %h want %h", k,
                   m_ivld ? instr_rdata : data_rdata, m_rdata);
        end
      end
      n_cmp++;
      if (instr_wait_cnt !== CW'(m_icnt) || data_wait_cnt !== CW'(m_dcnt)) begin
        n_err++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", k, instr_wait_cnt,
                 data_wait_cnt, m_icnt, m_dcnt);
      end
      tick();
      if (w == 0) ipend = 0;
      if (w == 1) dpend = 0;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    idle_inputs();
    rst_n    = 0;
    ram_init = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    @(posedge clk);
    #1;
    ram_init = 0;
    test_reset();
    test_instr_reads();
    test_data_write_read();
    test_contention();
    test_saturation();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
